// File: rtl/writeback_unit_pkg.sv
// ---------------------------------------------------------------------------
// writeback_unit_pkg
// Shared constants and types for the writeback stage.
//   W_OPR    operand / write data width
//   N_REG    number of architectural registers (one wb strobe per register)
//   W_RADDR  register index width
//   Q_DEPTH  entries per source queue (the queue logic assumes exactly 2)
//   W_ENTRY  width of one queued result {dst, data}
// ---------------------------------------------------------------------------
package writeback_unit_pkg;

  localparam int W_OPR   = 32;
  localparam int N_REG   = 32;
  localparam int W_RADDR = 5;
  localparam int Q_DEPTH = 2;
  localparam int W_ENTRY = W_RADDR + W_OPR;

  // One completed result waiting for write-back.
  typedef struct packed {
    logic [W_RADDR-1:0] dst;
    logic [W_OPR-1:0]   data;
  } wb_entry_t;

  // Source identity, used by the round-robin pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  // Register 0 is hard-wired; results aimed at it are consumed silently.
  function automatic logic is_arch_reg(input logic [W_RADDR-1:0] dst);
    return dst != '0;
  endfunction

endpackage

// File: rtl/writeback_unit_wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue
// Two-entry FIFO holding completed results for one producer.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset (empties the queue)
//   push        write push_entry at the tail (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   push_entry  entry to enqueue
//   head_entry  current head entry (valid when not_empty)
//   not_empty   queue holds at least one entry
//   not_full    queue can accept an entry; depends on occupancy only
// ---------------------------------------------------------------------------
module wb_queue
  import writeback_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output wb_entry_t head_entry,
  output logic      not_empty,
  output logic      not_full
);

  logic [W_ENTRY-1:0] slot_reg [Q_DEPTH];
  logic               rd_ptr_reg;
  logic               wr_ptr_reg;
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  logic               push_ok;
  logic               pop_ok;

  // Guard locally so a careless caller cannot corrupt the occupancy count.
  assign push_ok = push && not_full;
  assign pop_ok  = pop && not_empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset: occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) slot_reg[wr_ptr_reg] <= push_entry;
  end

  assign head_entry = slot_reg[rd_ptr_reg];
  assign not_empty  = count_reg != 2'd0;
  assign not_full   = count_reg != 2'(Q_DEPTH);

endmodule

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Collects results from the ALU and the load unit, picks at most one per
// cycle with a round-robin arbiter and drives a registered one-hot write
// strobe plus shared write data to the register cells.
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-low reset
//   alu_valid_i/ready_o/dst_i/data_i   ALU result handshake
//   mem_valid_i/ready_o/dst_i/data_i   load result handshake
//   w_reserve_vec_i  write-reserve bits of all cells
//   wb_o             one-hot write strobes (registered)
//   wb_data_o        write data, common to all cells (registered)
//   err_o            sticky: write-back hit a register that was not reserved
// ---------------------------------------------------------------------------
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid_i,
  output logic               alu_ready_o,
  input  logic [W_RADDR-1:0] alu_dst_i,
  input  logic [W_OPR-1:0]   alu_data_i,
  input  logic               mem_valid_i,
  output logic               mem_ready_o,
  input  logic [W_RADDR-1:0] mem_dst_i,
  input  logic [W_OPR-1:0]   mem_data_i,
  input  logic [N_REG-1:0]   w_reserve_vec_i,
  output logic [N_REG-1:0]   wb_o,
  output logic [W_OPR-1:0]   wb_data_o,
  output logic               err_o
);

  wb_entry_t          alu_entry;
  wb_entry_t          mem_entry;
  wb_entry_t          alu_head;
  wb_entry_t          mem_head;
  wb_entry_t          grant_entry;
  logic               alu_push;
  logic               mem_push;
  logic               alu_not_empty;
  logic               mem_not_empty;
  logic               alu_not_full;
  logic               mem_not_full;
  logic               grant_alu;
  logic               grant_mem;
  logic               grant_valid;
  logic               err_hit;
  logic [N_REG-1:0]   wb_next;

  logic [N_REG-1:0]   wb_reg;
  logic [W_OPR-1:0]   wb_data_reg;
  logic               err_reg;
  wb_src_e            last_grant_reg;

  // ---------------- source queues ----------------
  assign alu_entry = '{dst: alu_dst_i, data: alu_data_i};
  assign mem_entry = '{dst: mem_dst_i, data: mem_data_i};

  // Ready comes from occupancy alone, so a transfer is valid && not_full.
  assign alu_ready_o = alu_not_full;
  assign mem_ready_o = mem_not_full;
  assign alu_push    = alu_valid_i && alu_not_full;
  assign mem_push    = mem_valid_i && mem_not_full;

  wb_queue u_alu_q (
    .clk        (clk),
    .rst        (rst),
    .push       (alu_push),
    .pop        (grant_alu),
    .push_entry (alu_entry),
    .head_entry (alu_head),
    .not_empty  (alu_not_empty),
    .not_full   (alu_not_full)
  );

  wb_queue u_mem_q (
    .clk        (clk),
    .rst        (rst),
    .push       (mem_push),
    .pop        (grant_mem),
    .push_entry (mem_entry),
    .head_entry (mem_head),
    .not_empty  (mem_not_empty),
    .not_full   (mem_not_full)
  );

  // ---------------- round-robin arbiter ----------------
  // Under contention the source that did not win last time goes first.
  // The pointer records the most recent grant of either kind.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_not_empty && mem_not_empty) begin
      if (last_grant_reg == SRC_ALU) grant_mem = 1'b1;
      else                           grant_alu = 1'b1;
    end else if (alu_not_empty) begin
      grant_alu = 1'b1;
    end else if (mem_not_empty) begin
      grant_mem = 1'b1;
    end
  end

  assign grant_valid = grant_alu || grant_mem;
  assign grant_entry = grant_mem ? mem_head : alu_head;

  // ---------------- one-hot decoder ----------------
  // Register 0 never gets a strobe; its entry is still popped.
  for (genvar gi = 0; gi < N_REG; gi++) begin : g_dec
    assign wb_next[gi] = grant_valid && is_arch_reg(grant_entry.dst) &&
                         (grant_entry.dst == W_RADDR'(gi));
  end

  // Reserve bit is sampled in the grant cycle, before the write clears it.
  assign err_hit = grant_valid && is_arch_reg(grant_entry.dst) &&
                   !w_reserve_vec_i[grant_entry.dst];

  // ---------------- output stage ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_reg         <= '0;
      wb_data_reg    <= '0;
      err_reg        <= 1'b0;
      last_grant_reg <= SRC_ALU;
    end else begin
      wb_reg <= wb_next;
      if (grant_valid) begin
        wb_data_reg    <= grant_entry.data;
        last_grant_reg <= grant_mem ? SRC_MEM : SRC_ALU;
      end
      if (err_hit) err_reg <= 1'b1;
    end
  end

  assign wb_o      = wb_reg;
  assign wb_data_o = wb_data_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
// Randomised and directed stimulus against a queue-based reference model.
// Expected writebacks go into a scoreboard queue; a negedge monitor pops and
// compares whenever the DUT shows a strobe.
// ---------------------------------------------------------------------------
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic        alu_ready_o;
  logic [4:0]  alu_dst_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic [4:0]  mem_dst_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] w_reserve_vec_i = '1;
  logic [31:0] wb_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  // reference model state
  ent_t mq_alu[$];
  ent_t mq_mem[$];
  ent_t exp_q[$];
  int   last_src = 0;       // 0 = ALU, 1 = MEM
  bit   model_err = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid_i     (alu_valid_i),
    .alu_ready_o     (alu_ready_o),
    .alu_dst_i       (alu_dst_i),
    .alu_data_i      (alu_data_i),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_dst_i       (mem_dst_i),
    .mem_data_i      (mem_data_i),
    .w_reserve_vec_i (w_reserve_vec_i),
    .wb_o            (wb_o),
    .wb_data_o       (wb_data_o),
    .err_o           (err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict, take the edge.
  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                      input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                      input logic [31:0] rsv);
    bit   a_x, m_x, have_g, push_exp, err_next;
    ent_t g, e;
    alu_valid_i = av; alu_dst_i = ad; alu_data_i = adat;
    mem_valid_i = mv; mem_dst_i = md; mem_data_i = mdat;
    w_reserve_vec_i = rsv;
    chk("alu_ready", 64'(alu_ready_o), 64'(mq_alu.size() < 2));
    chk("mem_ready", 64'(mem_ready_o), 64'(mq_mem.size() < 2));
    a_x = av && (mq_alu.size() < 2);
    m_x = mv && (mq_mem.size() < 2);
    have_g = 1'b0; push_exp = 1'b0; err_next = model_err; g = '0;
    if (mq_alu.size() > 0 && mq_mem.size() > 0) begin
      have_g = 1'b1;
      if (last_src == 0) begin g = mq_mem.pop_front(); last_src = 1; end
      else               begin g = mq_alu.pop_front(); last_src = 0; end
    end else if (mq_alu.size() > 0) begin
      have_g = 1'b1; g = mq_alu.pop_front(); last_src = 0;
    end else if (mq_mem.size() > 0) begin
      have_g = 1'b1; g = mq_mem.pop_front(); last_src = 1;
    end
    if (have_g && g.dst != 0) begin
      push_exp = 1'b1;
      if (!rsv[g.dst]) err_next = 1'b1;
    end
    if (a_x) begin e.dst = ad; e.data = adat; mq_alu.push_back(e); end
    if (m_x) begin e.dst = md; e.data = mdat; mq_mem.push_back(e); end
    @(posedge clk);
    if (push_exp) exp_q.push_back(g);
    model_err = err_next;
    #1;
  endtask

  task automatic idle(input logic [31:0] rsv);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rsv);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    ent_t e;
    if (rst === 1'b1) begin
      chk("err_o", 64'(err_o), 64'(model_err));
      chk("onehot", 64'($countones(wb_o) <= 1), 64'd1);
      if (wb_o != '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb actual=%0h required=none t=%0t", wb_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_o", 64'(wb_o), 64'(32'd1 << e.dst));
          chk("wb_data", 64'(wb_data_o), 64'(e.data));
        end
      end
      chk("wb_pending", 64'(exp_q.size()), 64'd0);
    end
  end

  initial begin
    int macc;
    int low_at;
    bit m_will;
    #1 rst = 1'b0;
    #2;
    chk("rst_wb_o", 64'(wb_o), 64'd0);
    chk("rst_wb_data", 64'(wb_data_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready_o), 64'd1);
    @(posedge clk); #1 rst = 1'b1;

    // single ALU write: visible after the following edge, for one cycle
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ALL);
    idle(ALL);
    chk("t1_wb_o", 64'(wb_o), 64'h8);
    chk("t1_wb_data", 64'(wb_data_o), 64'hDEADBEEF);
    chk("t1_err", 64'(err_o), 64'd0);
    idle(ALL);
    chk("t1_pulse_end", 64'(wb_o), 64'd0);
    chk("t1_data_hold", 64'(wb_data_o), 64'hDEADBEEF);

    // simultaneous arrival: MEM first, then ALU
    step(1'b1, 5'd5, 32'd1, 1'b1, 5'd6, 32'd2, ALL);
    idle(ALL);
    chk("t2_first", 64'(wb_o), 64'h40);
    chk("t2_first_data", 64'(wb_data_o), 64'd2);
    idle(ALL);
    chk("t2_second", 64'(wb_o), 64'h20);
    chk("t2_second_data", 64'(wb_data_o), 64'd1);
    idle(ALL);

    // one MEM write so the ALU wins the next contention
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, ALL);
    idle(ALL);

    // backpressure on MEM with the ALU kept busy
    macc = 0; low_at = -1;
    for (int i = 0; i < 30 && macc < 4; i++) begin
      if (!mem_ready_o && low_at < 0) low_at = macc;
      m_will = mq_mem.size() < 2;
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'(10 + macc),
           32'h1000 + 32'(macc), ALL);
      if (m_will) macc++;
    end
    chk("t3_mem_accepts", 64'(macc), 64'd4);
    chk("t3_ready_drop_at", 64'(low_at), 64'd2);
    repeat (8) idle(ALL);

    // register 0 is consumed silently
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, ALL);
    idle(ALL);
    chk("t4_r0_wb", 64'(wb_o), 64'd0);
    chk("t4_r0_err", 64'(err_o), 64'd0);
    chk("t4_r0_ready", 64'(alu_ready_o), 64'd1);
    // write to unreserved register 9
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, ALL & ~32'h200);
    idle(ALL & ~32'h200);
    chk("t4_wb9", 64'(wb_o), 64'h200);
    chk("t4_err_set", 64'(err_o), 64'd1);
    idle(ALL); idle(ALL);
    chk("t4_err_sticky", 64'(err_o), 64'd1);

    // reset in the middle of traffic
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)),
           $urandom, ALL);
    #2 rst = 1'b0;
    mq_alu.delete(); mq_mem.delete(); exp_q.delete();
    last_src = 0; model_err = 1'b0;
    alu_valid_i = 1'b0; mem_valid_i = 1'b0;
    #1;
    chk("t5_wb_o", 64'(wb_o), 64'd0);
    chk("t5_wb_data", 64'(wb_data_o), 64'd0);
    chk("t5_err", 64'(err_o), 64'd0);
    chk("t5_alu_ready", 64'(alu_ready_o), 64'd1);
    chk("t5_mem_ready", 64'(mem_ready_o), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) idle(ALL);
    chk("t5_no_stale", 64'(wb_o), 64'd0);

    // random stress
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom, ALL);
    repeat (10) idle(ALL);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
